// File: rtl/slv_guard_mc_pkg.sv
// ============================================================================
// Module   : slv_guard_mc_pkg
// Brief    : Shared types for the multi-channel subordinate guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package slv_guard_mc_pkg;

  localparam int unsigned CNT_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FAULT = 2'd1,
    ST_RESET = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_SPURIOUS = 2'd2
  } cause_e;

  typedef logic [CNT_WIDTH-1:0] budget_t;

endpackage

`default_nettype wire

// File: rtl/slv_guard_id_tracker.sv
// ============================================================================
// Module   : slv_guard_id_tracker
// Brief    : Per-ID outstanding counters and response timers for one channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slv_guard_id_tracker
  import slv_guard_mc_pkg::*;
#(
  parameter int unsigned IdWidth      = 2,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned CntWidth     = CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    guard_ena_i,
  input  logic [CntWidth-1:0]     budget_i,
  input  logic                    req_acc_i,
  input  logic [IdWidth-1:0]      req_id_i,
  input  logic                    rsp_hs_i,
  input  logic                    rsp_last_i,
  input  logic [IdWidth-1:0]      rsp_id_i,
  output logic                    full_o,
  output logic                    rsp_zero_o,
  output logic                    spurious_o,
  output logic [IdWidth-1:0]      spurious_id_o,
  output logic [2**IdWidth-1:0]   timeout_vec_o
);

  localparam int unsigned NumIds  = 2**IdWidth;
  localparam int unsigned TxnCntW = $clog2(MaxTxnsPerId + 1);
  localparam logic [TxnCntW-1:0] MaxCnt = TxnCntW'(MaxTxnsPerId);
  localparam logic [CntWidth-1:0] TmrMax = '1;

  logic [TxnCntW-1:0]  cnt_q [NumIds];
  logic [TxnCntW-1:0]  cnt_d [NumIds];
  logic [CntWidth-1:0] tmr_q [NumIds];
  logic [CntWidth-1:0] tmr_d [NumIds];
  logic [NumIds-1:0]   acc;
  logic [NumIds-1:0]   ret;
  logic [NumIds-1:0]   busy;
  logic                tmr_run;

  assign tmr_run       = guard_ena_i & (budget_i != '0);
  assign full_o        = (cnt_q[req_id_i] == MaxCnt);
  assign rsp_zero_o    = (cnt_q[rsp_id_i] == '0);
  assign spurious_o    = rsp_hs_i & rsp_zero_o;
  assign spurious_id_o = rsp_id_i;

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      acc[i]           = req_acc_i && (req_id_i == IdWidth'(i));
      ret[i]           = rsp_hs_i && rsp_last_i && (rsp_id_i == IdWidth'(i));
      busy[i]          = (cnt_q[i] != '0);
      cnt_d[i]         = cnt_q[i];
      tmr_d[i]         = tmr_q[i];
      timeout_vec_o[i] = busy[i] && (budget_i != '0) && (tmr_q[i] >= budget_i);
      if (clr_i) begin
        cnt_d[i] = '0;
        tmr_d[i] = '0;
      end else begin
        // A retire against an empty counter is spurious and leaves it at zero.
        if (acc[i] && !(ret[i] && busy[i])) begin
          cnt_d[i] = cnt_q[i] + TxnCntW'(1);
        end else if (!acc[i] && ret[i] && busy[i]) begin
          cnt_d[i] = cnt_q[i] - TxnCntW'(1);
        end
        if ((acc[i] && !busy[i]) || ret[i]) begin
          tmr_d[i] = '0;
        end else if (busy[i] && tmr_run) begin
          tmr_d[i] = (tmr_q[i] == TmrMax) ? tmr_q[i] : tmr_q[i] + CntWidth'(1);
        end else begin
          tmr_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i] <= '0;
        tmr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumIds; i++) begin
        cnt_q[i] <= cnt_d[i];
        tmr_q[i] <= tmr_d[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/slv_guard_mc.sv
// ============================================================================
// Module   : slv_guard_mc
// Brief    : Multi-channel subordinate guard: timeout/spurious detection,
//            isolation and reset handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slv_guard_mc
  import slv_guard_mc_pkg::*;
#(
  parameter int unsigned NumChannels  = 2,
  parameter int unsigned IdWidth      = 2,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned CntWidth     = CNT_WIDTH,
  localparam int unsigned ChW         = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            guard_ena_i,
  input  logic [NumChannels*CntWidth-1:0] budget_i,
  input  logic [NumChannels-1:0]          mst_req_valid_i,
  output logic [NumChannels-1:0]          mst_req_ready_o,
  input  logic [NumChannels*IdWidth-1:0]  mst_req_id_i,
  output logic [NumChannels-1:0]          slv_req_valid_o,
  input  logic [NumChannels-1:0]          slv_req_ready_i,
  input  logic [NumChannels-1:0]          slv_rsp_valid_i,
  output logic [NumChannels-1:0]          slv_rsp_ready_o,
  input  logic [NumChannels*IdWidth-1:0]  slv_rsp_id_i,
  input  logic [NumChannels-1:0]          slv_rsp_last_i,
  output logic [NumChannels-1:0]          mst_rsp_valid_o,
  input  logic [NumChannels-1:0]          mst_rsp_ready_i,
  output logic                            irq_o,
  output logic                            rst_req_o,
  input  logic                            rst_stat_i,
  output logic [1:0]                      fault_cause_o,
  output logic [ChW-1:0]                  fault_ch_o,
  output logic [IdWidth-1:0]              fault_id_o
);

  localparam int unsigned NumIds = 2**IdWidth;

  logic [NumChannels-1:0]              full;
  logic [NumChannels-1:0]              rsp_zero;
  logic [NumChannels-1:0]              spurious;
  logic [NumChannels-1:0]              req_acc;
  logic [NumChannels-1:0]              rsp_hs;
  logic [NumChannels-1:0][NumIds-1:0]  timeout_vec;
  logic [NumChannels-1:0][IdWidth-1:0] spurious_id;

  state_e              state_q, state_d;
  cause_e              fault_cause_q, fault_cause_d;
  logic [ChW-1:0]      fault_ch_q, fault_ch_d;
  logic [IdWidth-1:0]  fault_id_q, fault_id_d;

  logic                hit;
  logic                det;
  cause_e              det_cause;
  logic [ChW-1:0]      det_ch;
  logic [IdWidth-1:0]  det_id;
  logic                run;

  assign run     = (state_q == ST_RUN);
  assign req_acc = mst_req_valid_i & mst_req_ready_o;
  assign rsp_hs  = slv_rsp_valid_i & slv_rsp_ready_o;

  generate
    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
      slv_guard_id_tracker #(
        .IdWidth      (IdWidth),
        .MaxTxnsPerId (MaxTxnsPerId),
        .CntWidth     (CntWidth)
      ) u_trk (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clr_i         (state_q == ST_CLEAR),
        .guard_ena_i   (guard_ena_i),
        .budget_i      (budget_i[c*CntWidth +: CntWidth]),
        .req_acc_i     (req_acc[c]),
        .req_id_i      (mst_req_id_i[c*IdWidth +: IdWidth]),
        .rsp_hs_i      (rsp_hs[c]),
        .rsp_last_i    (slv_rsp_last_i[c]),
        .rsp_id_i      (slv_rsp_id_i[c*IdWidth +: IdWidth]),
        .full_o        (full[c]),
        .rsp_zero_o    (rsp_zero[c]),
        .spurious_o    (spurious[c]),
        .spurious_id_o (spurious_id[c]),
        .timeout_vec_o (timeout_vec[c])
      );
    end
  endgenerate

  // Scan from the highest index down so the lowest (channel, ID) is the last
  // writer; on one (channel, ID) a timeout beats a spurious response.
  always_comb begin
    hit       = 1'b0;
    det_cause = CAUSE_NONE;
    det_ch    = '0;
    det_id    = '0;
    for (int c = NumChannels - 1; c >= 0; c--) begin
      for (int i = NumIds - 1; i >= 0; i--) begin
        if (timeout_vec[c][i] || (spurious[c] && (spurious_id[c] == IdWidth'(i)))) begin
          hit       = 1'b1;
          det_cause = timeout_vec[c][i] ? CAUSE_TIMEOUT : CAUSE_SPURIOUS;
          det_ch    = ChW'(c);
          det_id    = IdWidth'(i);
        end
      end
    end
    det = hit & run & guard_ena_i;
  end

  always_comb begin
    state_d       = state_q;
    fault_cause_d = fault_cause_q;
    fault_ch_d    = fault_ch_q;
    fault_id_d    = fault_id_q;
    case (state_q)
      ST_RUN: begin
        if (det) begin
          state_d       = ST_FAULT;
          fault_cause_d = det_cause;
          fault_ch_d    = det_ch;
          fault_id_d    = det_id;
        end
      end
      ST_FAULT: if (rst_stat_i)  state_d = ST_RESET;
      ST_RESET: if (!rst_stat_i) state_d = ST_CLEAR;
      ST_CLEAR: begin
        state_d       = ST_RUN;
        fault_cause_d = CAUSE_NONE;
        fault_ch_d    = '0;
        fault_id_d    = '0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outside RUN every channel is isolated and responses are drained.
  always_comb begin
    mst_req_ready_o = run ? (slv_req_ready_i & ~full)     : '0;
    slv_req_valid_o = run ? (mst_req_valid_i & ~full)     : '0;
    slv_rsp_ready_o = run ? mst_rsp_ready_i               : '1;
    mst_rsp_valid_o = run ? (slv_rsp_valid_i & ~rsp_zero) : '0;
    irq_o           = (state_q == ST_FAULT) || (state_q == ST_RESET);
    rst_req_o       = (state_q == ST_FAULT) && !rst_stat_i;
  end

  assign fault_cause_o = fault_cause_q;
  assign fault_ch_o    = fault_ch_q;
  assign fault_id_o    = fault_id_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_RUN;
      fault_cause_q <= CAUSE_NONE;
      fault_ch_q    <= '0;
      fault_id_q    <= '0;
    end else begin
      state_q       <= state_d;
      fault_cause_q <= fault_cause_d;
      fault_ch_q    <= fault_ch_d;
      fault_id_q    <= fault_id_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_slv_guard_mc.sv
// ============================================================================
// Module   : tb_slv_guard_mc
// Brief    : Self-checking bench for slv_guard_mc with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_slv_guard_mc;
  import slv_guard_mc_pkg::*;

  localparam int NCH  = 2;
  localparam int IDW  = 2;
  localparam int NID  = 4;
  localparam int MAXT = 4;
  localparam int CW   = CNT_WIDTH;
  localparam int M_RUN = 0, M_FAULT = 1, M_RESET = 2, M_CLEAR = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               guard_ena = 1'b1;
  logic [NCH*CW-1:0]  budget = '0;
  logic [NCH-1:0]     req_valid = '0, req_ready, slv_req_valid, slv_req_ready = '0;
  logic [NCH*IDW-1:0] req_id = '0, rsp_id = '0;
  logic [NCH-1:0]     rsp_valid = '0, rsp_ready, rsp_last = '0;
  logic [NCH-1:0]     mst_rsp_valid, mst_rsp_ready = '0;
  logic               irq, rst_req, rst_stat = 1'b0;
  logic [1:0]         fault_cause;
  logic [0:0]         fault_ch;
  logic [IDW-1:0]     fault_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slv_guard_mc #(
    .NumChannels(NCH), .IdWidth(IDW), .MaxTxnsPerId(MAXT), .CntWidth(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .guard_ena_i(guard_ena), .budget_i(budget),
    .mst_req_valid_i(req_valid), .mst_req_ready_o(req_ready), .mst_req_id_i(req_id),
    .slv_req_valid_o(slv_req_valid), .slv_req_ready_i(slv_req_ready),
    .slv_rsp_valid_i(rsp_valid), .slv_rsp_ready_o(rsp_ready), .slv_rsp_id_i(rsp_id),
    .slv_rsp_last_i(rsp_last), .mst_rsp_valid_o(mst_rsp_valid),
    .mst_rsp_ready_i(mst_rsp_ready), .irq_o(irq), .rst_req_o(rst_req),
    .rst_stat_i(rst_stat), .fault_cause_o(fault_cause), .fault_ch_o(fault_ch),
    .fault_id_o(fault_id)
  );

  // Behavioural model state
  int m_cnt [NCH][NID];
  int m_tmr [NCH][NID];
  int m_mode = M_RUN;
  int m_cause = 0, m_ch = 0, m_id = 0;
  bit started = 1'b0;
  logic [NCH-1:0] e_mrr, e_srv, e_srr, e_mrv;
  logic e_irq, e_rrq;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic calc();
    for (int c = 0; c < NCH; c++) begin
      int rid;
      int sid;
      bit full;
      rid  = int'(req_id[c*IDW +: IDW]);
      sid  = int'(rsp_id[c*IDW +: IDW]);
      full = (m_cnt[c][rid] == MAXT);
      if (m_mode == M_RUN) begin
        e_mrr[c] = slv_req_ready[c] && !full;
        e_srv[c] = req_valid[c] && !full;
        e_srr[c] = mst_rsp_ready[c];
        e_mrv[c] = rsp_valid[c] && (m_cnt[c][sid] != 0);
      end else begin
        e_mrr[c] = 1'b0;
        e_srv[c] = 1'b0;
        e_srr[c] = 1'b1;
        e_mrv[c] = 1'b0;
      end
    end
    e_irq = (m_mode == M_FAULT) || (m_mode == M_RESET);
    e_rrq = (m_mode == M_FAULT) && !rst_stat;
  endtask

  task automatic model_step();
    int old;
    bit det;
    int dc, di, dcause;
    calc();
    if (rst) begin
      m_mode = M_RUN; m_cause = 0; m_ch = 0; m_id = 0;
      for (int c = 0; c < NCH; c++)
        for (int i = 0; i < NID; i++) begin m_cnt[c][i] = 0; m_tmr[c][i] = 0; end
      return;
    end
    old = m_mode; det = 1'b0; dc = 0; di = 0; dcause = 0;
    if (old == M_RUN && guard_ena) begin
      for (int c = 0; c < NCH; c++) begin
        for (int i = 0; i < NID; i++) begin
          int b;
          bit to, sp;
          b  = int'(budget[c*CW +: CW]);
          to = (m_cnt[c][i] > 0) && (b != 0) && (m_tmr[c][i] >= b);
          sp = rsp_valid[c] && e_srr[c] && (int'(rsp_id[c*IDW +: IDW]) == i) && (m_cnt[c][i] == 0);
          if (!det && (to || sp)) begin
            det = 1'b1; dc = c; di = i; dcause = to ? 1 : 2;
          end
        end
      end
    end
    case (old)
      M_RUN:   if (det) begin m_mode = M_FAULT; m_cause = dcause; m_ch = dc; m_id = di; end
      M_FAULT: if (rst_stat) m_mode = M_RESET;
      M_RESET: if (!rst_stat) m_mode = M_CLEAR;
      default: begin m_mode = M_RUN; m_cause = 0; m_ch = 0; m_id = 0; end
    endcase
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < NID; i++) begin
        int b, n;
        bit acc, ret;
        if (old == M_CLEAR) begin
          m_cnt[c][i] = 0; m_tmr[c][i] = 0;
        end else begin
          b   = int'(budget[c*CW +: CW]);
          acc = req_valid[c] && e_mrr[c] && (int'(req_id[c*IDW +: IDW]) == i);
          ret = rsp_valid[c] && e_srr[c] && rsp_last[c] && (int'(rsp_id[c*IDW +: IDW]) == i);
          n   = m_cnt[c][i] + (acc ? 1 : 0) - ((ret && m_cnt[c][i] > 0) ? 1 : 0);
          if ((m_cnt[c][i] == 0 && n > 0) || ret) m_tmr[c][i] = 0;
          else if (m_cnt[c][i] > 0 && guard_ena && b != 0)
            m_tmr[c][i] = (m_tmr[c][i] + 1 > 1023) ? 1023 : m_tmr[c][i] + 1;
          else m_tmr[c][i] = 0;
          m_cnt[c][i] = n;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      calc();
      check("mst_req_ready", 32'(req_ready), 32'(e_mrr));
      check("slv_req_valid", 32'(slv_req_valid), 32'(e_srv));
      check("slv_rsp_ready", 32'(rsp_ready), 32'(e_srr));
      check("mst_rsp_valid", 32'(mst_rsp_valid), 32'(e_mrv));
      check("irq", 32'(irq), 32'(e_irq));
      check("rst_req", 32'(rst_req), 32'(e_rrq));
      check("fault_cause", 32'(fault_cause), 32'(m_cause));
      check("fault_ch", 32'(fault_ch), 32'(m_ch));
      check("fault_id", 32'(fault_id), 32'(m_id));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_budget(input budget_t b0, input budget_t b1);
    budget = {b1, b0};
  endtask

  task automatic do_clear();
    rst_stat = 1'b1;
    repeat (3) tick();
    rst_stat = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    set_budget(budget_t'(5), budget_t'(5));
    slv_req_ready = 2'b11;
    mst_rsp_ready = 2'b11;
    repeat (2) tick();
    check("rst_irq", 32'(irq), 0);
    check("rst_rst_req", 32'(rst_req), 0);
    check("rst_cause", 32'(fault_cause), 0);
    check("rst_id", 32'(fault_id), 0);
    rst = 1'b0;
    tick();

    // Timeout on ch0 ID1, then full reset handshake
    req_valid = 2'b01; req_id = 4'b0001;
    tick();
    req_valid = 2'b00;
    repeat (5) tick();
    check("t1_irq_c6", 32'(irq), 0);
    tick();
    check("t1_irq_c7", 32'(irq), 1);
    check("t1_rst_req", 32'(rst_req), 1);
    check("t1_cause", 32'(fault_cause), 1);
    check("t1_ch", 32'(fault_ch), 0);
    check("t1_id", 32'(fault_id), 1);
    req_valid = 2'b11;
    #1 check("t1_isolate", 32'(slv_req_valid), 0);
    req_valid = 2'b00;
    rst_stat = 1'b1;
    #1 check("hs_rst_req_fall", 32'(rst_req), 0);
    check("hs_irq_hold", 32'(irq), 1);
    repeat (10) tick();
    rst_stat = 1'b0;
    tick();
    check("hs_clear_irq", 32'(irq), 0);
    tick();
    slv_req_ready = 2'b00; req_valid = 2'b01; req_id = 4'b0000;
    #1 check("hs_traffic", 32'(slv_req_valid[0]), 1);
    check("hs_cause_zero", 32'(fault_cause), 0);
    req_valid = 2'b00; slv_req_ready = 2'b11;
    tick();

    // Retire in cycle 5 prevents the fault
    req_valid = 2'b01; req_id = 4'b0001;
    tick();
    req_valid = 2'b00;
    repeat (4) tick();
    rsp_valid = 2'b01; rsp_id = 4'b0001; rsp_last = 2'b01;
    #1 check("t2_rsp_fwd", 32'(mst_rsp_valid[0]), 1);
    tick();
    rsp_valid = 2'b00;
    repeat (6) tick();
    check("t2_no_irq", 32'(irq), 0);

    // Outstanding limit on ch1 ID2 (ch1 timeout disabled)
    set_budget(budget_t'(5), budget_t'(0));
    req_valid = 2'b10; req_id = 4'b1000;
    repeat (4) tick();
    check("t3_stall_a", 32'(req_ready[1]), 0);
    tick();
    check("t3_stall_b", 32'(req_ready[1]), 0);
    rsp_valid = 2'b10; rsp_id = 4'b1000; rsp_last = 2'b10;
    #1 check("t3_stall_c", 32'(req_ready[1]), 0);
    tick();
    rsp_valid = 2'b00;
    #1 check("t3_unstall", 32'(req_ready[1]), 1);
    tick();
    req_valid = 2'b00;
    rsp_valid = 2'b10;
    repeat (4) tick();
    rsp_valid = 2'b00; rsp_last = 2'b00;
    tick();
    set_budget(budget_t'(5), budget_t'(5));

    // Spurious response on ch1 ID3
    rsp_valid = 2'b10; rsp_id = 4'b1100; rsp_last = 2'b10;
    #1 check("t4_blocked", 32'(mst_rsp_valid[1]), 0);
    tick();
    rsp_valid = 2'b00; rsp_last = 2'b00;
    check("t4_irq", 32'(irq), 1);
    check("t4_cause", 32'(fault_cause), 2);
    check("t4_ch", 32'(fault_ch), 1);
    check("t4_id", 32'(fault_id), 3);
    do_clear();

    // Simultaneous timeouts: ch0 ID3 beats ch1 ID0; then rst_i mid-fault
    req_valid = 2'b11; req_id = 4'b0011;
    tick();
    req_valid = 2'b00;
    repeat (6) tick();
    check("t5_cause", 32'(fault_cause), 1);
    check("t5_ch", 32'(fault_ch), 0);
    check("t5_id", 32'(fault_id), 3);
    rst = 1'b1;
    tick();
    check("t5_rst_irq", 32'(irq), 0);
    check("t5_rst_rst_req", 32'(rst_req), 0);
    check("t5_rst_cause", 32'(fault_cause), 0);
    check("t5_rst_id", 32'(fault_id), 0);
    check("t5_rst_rsp_ready", 32'(rsp_ready), 32'h3);
    rst = 1'b0;
    tick();

    // Guard disabled: spurious response raises nothing
    guard_ena = 1'b0;
    rsp_valid = 2'b01; rsp_id = 4'b0000; rsp_last = 2'b01;
    tick();
    rsp_valid = 2'b00; rsp_last = 2'b00;
    check("t6_no_irq", 32'(irq), 0);
    guard_ena = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
